// File: rtl/ram_param.sv
// Single-port RAM with combinational read. After every reset it runs a zeroing
// sweep, and stays busy with reads masked until every word has been cleared.
module ram_param #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];

  // Control FSM: clr_cnt walks every word once, then wraps back to zero as the FSM enters READY.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {ADDR_W{1'b1}}) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          clr_cnt <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the sweep is the only thing that initialises it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[clr_cnt] <= '0;
      else if (load)
        mem[address] <= in;
    end
  end

  assign out = (state == READY) ? mem[address] : '0;

endmodule

// File: tb/tb_ram_param.sv
// Scoreboarded bench for ram_param: a default 512x16 instance and a small 8x8 instance.
module tb_ram_param;

  logic        clock = 1'b0;
  logic        rst0, rst1;
  logic [15:0] in0;
  logic [8:0]  addr0;
  logic        load0;
  logic [15:0] out0;
  logic        busy0;
  logic [7:0]  in1;
  logic [2:0]  addr1;
  logic        load1;
  logic [7:0]  out1;
  logic        busy1;

  int checks = 0;
  int errors = 0;

  ram_param dut0 (
    .clock(clock), .reset(rst0), .in(in0), .address(addr0),
    .load(load0), .out(out0), .busy(busy0)
  );

  ram_param #(.WIDTH(8), .ADDR_W(3)) dut1 (
    .clock(clock), .reset(rst1), .in(in1), .address(addr1),
    .load(load1), .out(out1), .busy(busy1)
  );

  always #5 clock = ~clock;

  // Reference model: a word array plus a count of sweep edges still owed.
  logic [15:0] mem0 [512];
  logic [7:0]  mem1 [8];
  logic        mbusy0 = 1'b1, mbusy1 = 1'b1;
  int          left0 = 512, left1 = 8;
  logic        mvalid = 1'b0;

  always @(posedge clock) begin
    mvalid = 1'b1;
    if (rst0) begin
      mbusy0 = 1'b1;
      left0  = 512;
    end else if (mbusy0) begin
      left0 = left0 - 1;
      if (left0 == 0) begin
        mbusy0 = 1'b0;
        for (int i = 0; i < 512; i++) mem0[i] = 16'h0;
      end
    end else if (load0) begin
      mem0[addr0] = in0;
    end
    if (rst1) begin
      mbusy1 = 1'b1;
      left1  = 8;
    end else if (mbusy1) begin
      left1 = left1 - 1;
      if (left1 == 0) begin
        mbusy1 = 1'b0;
        for (int i = 0; i < 8; i++) mem1[i] = 8'h0;
      end
    end else if (load1) begin
      mem1[addr1] = in1;
    end
  end

  typedef struct {
    int          inst;
    string       nm;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: busy against the model every cycle, queued read expectations against out.
  always @(negedge clock) begin
    exp_t e;
    if (mvalid) begin
      chk("busy0", {31'h0, busy0}, {31'h0, mbusy0});
      chk("busy1", {31'h0, busy1}, {31'h0, mbusy1});
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.inst == 0) chk(e.nm, {16'h0, out0}, {16'h0, e.exp});
      else             chk(e.nm, {24'h0, out1}, {16'h0, e.exp});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect0(input string nm, input logic [8:0] a);
    exp_t e;
    addr0 = a;
    load0 = 1'b0;
    e.inst = 0;
    e.nm   = nm;
    e.exp  = mbusy0 ? 16'h0 : mem0[a];
    q.push_back(e);
  endtask

  task automatic expect1(input string nm, input logic [2:0] a);
    exp_t e;
    addr1 = a;
    load1 = 1'b0;
    e.inst = 1;
    e.nm   = nm;
    e.exp  = mbusy1 ? 16'h0 : {8'h0, mem1[a]};
    q.push_back(e);
  endtask

  task automatic write0(input logic [8:0] a, input logic [15:0] d);
    addr0 = a;
    in0   = d;
    load0 = 1'b1;
    tick();
    load0 = 1'b0;
  endtask

  task automatic count_busy0(output int n);
    n = 0;
    while (busy0 && n < 2000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [8:0]  a, ra;
    logic [15:0] d;
    rst0 = 1'b1; rst1 = 1'b1;
    in0 = '0; addr0 = '0; load0 = 1'b0;
    in1 = '0; addr1 = '0; load1 = 1'b0;

    tick();
    expect0("out_in_reset", 9'd37);
    tick();
    rst0 = 1'b0;

    // User writes during the sweep must be dropped.
    addr0 = 9'd5; in0 = 16'h1111; load0 = 1'b1;
    count_busy0(n);
    load0 = 1'b0;
    chk("sweep_len", n, 512);
    expect0("clr_a0", 9'd0);   tick();
    expect0("clr_a37", 9'd37); tick();
    expect0("clr_a511", 9'd511); tick();
    expect0("drop_a5", 9'd5);  tick();

    write0(9'd37, 16'hBEEF);
    expect0("wr_a37", 9'd37); tick();
    expect0("nb_a36", 9'd36); tick();
    expect0("nb_a38", 9'd38); tick();
    addr0 = 9'd37; in0 = 16'd1234; load0 = 1'b0;
    tick();
    expect0("noload_a37", 9'd37); tick();

    for (int i = 0; i < 40; i++) begin
      a = 9'($urandom_range(0, 511));
      d = 16'($urandom);
      write0(a, d);
      ra = ($urandom_range(0, 1) == 1) ? a : 9'($urandom_range(0, 511));
      expect0("rand_rd", ra);
      tick();
    end
    write0(9'd0, 16'h0F0F);
    write0(9'd511, 16'h00FF);
    expect0("edge_a511", 9'd511); tick();
    expect0("edge_a0", 9'd0); tick();

    // Reset from READY, then again mid-sweep at edge 100.
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    expect0("mid_sweep_out", 9'd511);
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    count_busy0(n);
    chk("resweep_len", n, 512);
    expect0("rst_a511", 9'd511); tick();
    expect0("rst_a0", 9'd0); tick();

    // Small instance.
    rst1 = 1'b0;
    n = 0;
    while (busy1 && n < 100) begin
      tick();
      n++;
    end
    chk("small_sweep_len", n, 8);
    addr1 = 3'd7; in1 = 8'hA5; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    expect1("small_a7", 3'd7); tick();
    expect1("small_a0", 3'd0); tick();
    tick();
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
